// File: rtl/latch_ctl_pkg.sv
// Shared types and elaboration helpers for the latch bank arbiter.
package latch_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OPEN  = 2'd2,
      HOLD  = 2'd3
   } latch_phase_t;

   typedef enum logic {
      XACT_WRITE = 1'b0,
      XACT_CLR   = 1'b1
   } latch_xact_t;

   // Every phase must last at least one cycle or lat_en/lat_rst could glitch.
   function automatic bit phase_len_ok(int setup_cyc, int open_cyc, int hold_cyc);
      return (setup_cyc >= 1) && (open_cyc >= 1) && (hold_cyc >= 1);
   endfunction

   function automatic int max3(int a, int b, int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/latch_bank_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   function automatic logic [PW-1:0] slot(logic [PW-1:0] base, int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!valid && req[slot(ptr, k)]) begin
            valid              = 1'b1;
            grant[slot(ptr, k)] = 1'b1;
            idx                = slot(ptr, k);
         end
      end
   end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Shares one latch bank between NREQ writers: round-robin pick, then a
// setup/open/hold enable sequence with an ack to the writer, or a bank clear.
//
//   state | meaning
//   IDLE  | nothing in flight, bank untouched
//   SETUP | lat_d (or clear) presented, enable still low
//   OPEN  | lat_en high for a write, lat_rst low for a clear
//   HOLD  | enable low, lat_d held; ack in the last cycle of a write
module latch_bank_arbiter
   import latch_ctl_pkg::*;
#(
   parameter int N         = 32,
   parameter int NREQ      = 4,
   parameter int SETUP_CYC = 1,
   parameter int OPEN_CYC  = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] wdata,
   input  logic              clr,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic              lat_en,
   output logic [N-1:0]      lat_d,
   output logic              lat_rst,
   output logic              busy
);

   localparam int PW      = $clog2(NREQ);
   localparam int MAX_CYC = max3(SETUP_CYC, OPEN_CYC, HOLD_CYC);
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

   generate
      if (!phase_len_ok(SETUP_CYC, OPEN_CYC, HOLD_CYC)) begin : g_bad_phase_len
         $error("latch_bank_arbiter: SETUP_CYC, OPEN_CYC and HOLD_CYC must all be >= 1");
      end
   endgenerate

   latch_phase_t      state, state_nxt;
   latch_xact_t       xact, xact_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [PW-1:0]     ptr;
   logic              clr_pend;
   logic              clr_cand;
   logic              clr_retire;
   logic              phase_done;
   logic              arb_go;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   win_oh;
   logic [PW-1:0]     win_idx;
   logic              win_valid;
   logic [N-1:0]      win_data;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req   (req),
      .ptr   (ptr),
      .grant (win_oh),
      .idx   (win_idx),
      .valid (win_valid)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) win_data = wdata[i*N +: N];
      end
   end

   assign phase_done = (cnt == '0);
   // A clear that is finishing its own HOLD must not win the arbitration it retires at.
   assign clr_cand   = clr_pend && !((state == HOLD) && (xact == XACT_CLR));
   assign clr_retire = (state == HOLD) && phase_done && (xact == XACT_CLR);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      arb_go    = 1'b0;
      xact_nxt  = xact;
      unique case (state)
         IDLE: begin
            if (win_valid || clr_cand) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               arb_go    = 1'b1;
            end
         end
         SETUP: begin
            if (phase_done) begin
               state_nxt = OPEN;
               cnt_nxt   = OPEN_LD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         OPEN: begin
            if (phase_done) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         HOLD: begin
            if (phase_done) begin
               if (win_valid || clr_cand) begin
                  state_nxt = SETUP;
                  cnt_nxt   = SETUP_LD;
                  arb_go    = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (arb_go) xact_nxt = clr_cand ? XACT_CLR : XACT_WRITE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         xact     <= XACT_WRITE;
         cnt      <= '0;
         ptr      <= '0;
         clr_pend <= 1'b0;
         gnt_q    <= '0;
         lat_d    <= '0;
         lat_en   <= 1'b0;
         lat_rst  <= 1'b1;
      end else begin
         state    <= state_nxt;
         xact     <= xact_nxt;
         cnt      <= cnt_nxt;
         clr_pend <= clr || (clr_pend && !clr_retire);
         // Enables are flops decoded from the next phase so they track OPEN exactly.
         lat_en   <= (state_nxt == OPEN) && (xact_nxt == XACT_WRITE);
         lat_rst  <= !((state_nxt == OPEN) && (xact_nxt == XACT_CLR));
         if (arb_go) begin
            if (clr_cand) begin
               gnt_q <= '0;
               lat_d <= '0;
            end else begin
               gnt_q <= win_oh;
               lat_d <= win_data;
               ptr   <= (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
            end
         end else if (state_nxt == IDLE) begin
            gnt_q <= '0;
         end
      end
   end

   assign gnt  = gnt_q;
   assign ack  = ((state == HOLD) && phase_done && (xact == XACT_WRITE)) ? gnt_q : '0;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: a default-phase instance and a 2/3/2 instance share
// stimulus and are each compared every cycle against a transaction-position model.
module tb_latch_bank_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;

   typedef struct packed {
      logic        act;
      logic [7:0]  pos;
      logic [1:0]  w;
      logic        clr_x;
      logic        clrp;
      logic [1:0]  ptr;
      logic [31:0] latd;
   } model_t;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] wdata;
   logic              clr;

   logic [NREQ-1:0] gnt_a, ack_a, gnt_b, ack_b;
   logic            lat_en_a, lat_rst_a, busy_a, lat_en_b, lat_rst_b, busy_b;
   logic [N-1:0]    lat_d_a, lat_d_b;

   model_t      ma, mb;
   logic [42:0] obs_a, obs_b, exp_a, exp_b;

   int n_checks = 0;
   int n_fails  = 0;

   latch_bank_arbiter #(.N(N), .NREQ(NREQ), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) dut_a (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
      .gnt(gnt_a), .ack(ack_a), .lat_en(lat_en_a), .lat_d(lat_d_a),
      .lat_rst(lat_rst_a), .busy(busy_a)
   );

   latch_bank_arbiter #(.N(N), .NREQ(NREQ), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) dut_b (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
      .gnt(gnt_b), .ack(ack_b), .lat_en(lat_en_b), .lat_d(lat_d_b),
      .lat_rst(lat_rst_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next model state: a transaction lasts tlen cycles; pos counts through it.
   function automatic model_t model_next(model_t m, int tlen, logic [3:0] r,
                                         logic [127:0] wd, logic c);
      model_t n;
      logic   last, cand, found;
      n     = m;
      last  = m.act && (int'(m.pos) == tlen - 1);
      cand  = m.clrp && !(last && m.clr_x);
      found = 1'b0;
      if (!m.act || last) begin
         n.act = 1'b0;
         if (cand) begin
            n.act = 1'b1; n.pos = '0; n.clr_x = 1'b1; n.latd = '0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (!found && r[(int'(m.ptr) + k) % 4]) begin
                  found   = 1'b1;
                  n.act   = 1'b1;
                  n.pos   = '0;
                  n.clr_x = 1'b0;
                  n.w     = 2'((int'(m.ptr) + k) % 4);
                  n.latd  = wd[n.w*32 +: 32];
                  n.ptr   = n.w + 2'd1;
               end
            end
         end
      end else begin
         n.pos = m.pos + 8'd1;
      end
      n.clrp = c || (m.clrp && !(last && m.clr_x));
      return n;
   endfunction

   function automatic logic [42:0] exp_of(model_t m, int s, int o, int t);
      logic [3:0] g, a;
      logic       in_open, en, rs;
      in_open = m.act && (int'(m.pos) >= s) && (int'(m.pos) < s + o);
      g  = (m.act && !m.clr_x) ? (4'b0001 << m.w) : 4'b0000;
      a  = (m.act && !m.clr_x && int'(m.pos) == t - 1) ? g : 4'b0000;
      en = in_open && !m.clr_x;
      rs = !(in_open && m.clr_x);
      return {g, a, en, rs, m.act, m.latd};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= model_next(ma, 3, req, wdata, clr);
         mb <= model_next(mb, 7, req, wdata, clr);
      end
   end

   assign exp_a = exp_of(ma, 1, 1, 3);
   assign exp_b = exp_of(mb, 2, 3, 7);
   assign obs_a = {gnt_a, ack_a, lat_en_a, lat_rst_a, busy_a, lat_d_a};
   assign obs_b = {gnt_b, ack_b, lat_en_b, lat_rst_b, busy_b, lat_d_b};

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = '0;
      clr = 1'b0;
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      req   = 4'b1111;
      clr   = 1'b0;
      wdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      cycle();
      n_checks++;
      if (obs_a !== {4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 32'b0}) begin
         n_fails++; $display("FAIL reset_a got=%h exp=%h", obs_a, {4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 32'b0});
      end
      n_checks++;
      if (obs_b !== {4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 32'b0}) begin
         n_fails++; $display("FAIL reset_b got=%h exp=%h", obs_b, {4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 32'b0});
      end
      rst = 1'b1;
      cycle();
      n_checks++;
      if ({gnt_a, gnt_b} !== {4'b0001, 4'b0001}) begin
         n_fails++; $display("FAIL reset_first_gnt got=%b_%b exp=0001_0001", gnt_a, gnt_b);
      end
      for (int c = 0; c < 20; c++) begin
         if (c == 8) req = '0;
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL reset_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
      end
   endtask

   task automatic test_single_write();
      do_reset();
      wdata = {$urandom, $urandom, $urandom, $urandom};
      wdata[2*32 +: 32] = 32'hDEADBEEF;
      req = 4'b0100;
      for (int c = 1; c <= 9; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL single_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         if (c == 1) begin
            n_checks++;
            if ({gnt_a, lat_d_a, lat_en_a} !== {4'b0100, 32'hDEADBEEF, 1'b0}) begin
               n_fails++; $display("FAIL single_setup got=%b %h %b exp=0100 deadbeef 0", gnt_a, lat_d_a, lat_en_a);
            end
            wdata[2*32 +: 32] = $urandom;
         end
         if (c == 2) begin
            n_checks++;
            if ({lat_en_a, ack_a} !== {1'b1, 4'b0000}) begin
               n_fails++; $display("FAIL single_open got=%b %b exp=1 0000", lat_en_a, ack_a);
            end
         end
         if (c == 3) begin
            n_checks++;
            if ({ack_a, lat_en_a, lat_d_a} !== {4'b0100, 1'b0, 32'hDEADBEEF}) begin
               n_fails++; $display("FAIL single_ack got=%b %b %h exp=0100 0 deadbeef", ack_a, lat_en_a, lat_d_a);
            end
            req = '0;
         end
         if (c == 4) begin
            n_checks++;
            if ({busy_a, gnt_a} !== {1'b0, 4'b0000}) begin
               n_fails++; $display("FAIL single_idle got=%b %b exp=0 0000", busy_a, gnt_a);
            end
         end
         if (c == 8) begin
            n_checks++;
            if (busy_b !== 1'b0) begin
               n_fails++; $display("FAIL single_idle_b got=%b exp=0", busy_b);
            end
         end
      end
   endtask

   task automatic test_fairness();
      do_reset();
      wdata = {$urandom, $urandom, $urandom, $urandom};
      req = 4'b1111;
      for (int c = 1; c <= 36; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL fair_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         if ((c - 1) % 3 == 0) begin
            n_checks++;
            if ({busy_a, gnt_a} !== {1'b1, 4'b0001 << (((c - 1) / 3) % 4)}) begin
               n_fails++; $display("FAIL fair_order c=%0d got=%b %b exp=1 %b", c, busy_a, gnt_a, 4'b0001 << (((c - 1) / 3) % 4));
            end
         end
      end
      req = '0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL fair_drain t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
      end
   endtask

   task automatic test_clear();
      do_reset();
      wdata = {$urandom, $urandom, $urandom, $urandom};
      req = 4'b0010;
      for (int c = 1; c <= 40; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL clear_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         clr = (c == 1);
         if (c == 3) begin
            n_checks++;
            if (ack_a !== 4'b0010) begin
               n_fails++; $display("FAIL clear_write_ack got=%b exp=0010", ack_a);
            end
            req = '0;
         end
         if (c == 4) begin
            n_checks++;
            if ({busy_a, gnt_a, lat_rst_a} !== {1'b1, 4'b0000, 1'b1}) begin
               n_fails++; $display("FAIL clear_setup got=%b %b %b exp=1 0000 1", busy_a, gnt_a, lat_rst_a);
            end
         end
         if (c == 5) begin
            n_checks++;
            if ({lat_rst_a, lat_en_a, gnt_a, ack_a, lat_d_a} !== {1'b0, 1'b0, 4'b0, 4'b0, 32'b0}) begin
               n_fails++; $display("FAIL clear_open got=%b %b %b %b %h exp=0 0 0000 0000 0", lat_rst_a, lat_en_a, gnt_a, ack_a, lat_d_a);
            end
            req = 4'b1111;
         end
         if (c == 6) begin
            n_checks++;
            if ({lat_rst_a, ack_a} !== {1'b1, 4'b0000}) begin
               n_fails++; $display("FAIL clear_hold got=%b %b exp=1 0000", lat_rst_a, ack_a);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (gnt_a !== 4'b0100) begin
               n_fails++; $display("FAIL clear_ptr_kept got=%b exp=0100", gnt_a);
            end
         end
         if (c == 24) req = '0;
      end
   endtask

   task automatic test_phase_lengths();
      logic [31:0] d0;
      int          en_cnt;
      do_reset();
      wdata  = {$urandom, $urandom, $urandom, $urandom};
      d0     = wdata[31:0];
      en_cnt = 0;
      req    = 4'b0001;
      for (int c = 1; c <= 12; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL phase_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         if (lat_en_b) en_cnt++;
         if (c <= 7) begin
            n_checks++;
            if ({gnt_b, lat_d_b} !== {4'b0001, d0}) begin
               n_fails++; $display("FAIL phase_lat_d c=%0d got=%b %h exp=0001 %h", c, gnt_b, lat_d_b, d0);
            end
         end
         if (c == 2) wdata[31:0] = ~d0;
         if (c == 6) begin
            n_checks++;
            if (ack_b !== 4'b0000) begin
               n_fails++; $display("FAIL phase_early_ack got=%b exp=0000", ack_b);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (ack_b !== 4'b0001) begin
               n_fails++; $display("FAIL phase_ack got=%b exp=0001", ack_b);
            end
            req = '0;
         end
         if (c == 8) begin
            n_checks++;
            if (busy_b !== 1'b0) begin
               n_fails++; $display("FAIL phase_idle got=%b exp=0", busy_b);
            end
         end
      end
      n_checks++;
      if (en_cnt !== 3) begin
         n_fails++; $display("FAIL phase_open_len got=%0d exp=3", en_cnt);
      end
   endtask

   task automatic test_abort();
      do_reset();
      wdata = {$urandom, $urandom, $urandom, $urandom};
      req = 4'b0001;
      for (int c = 1; c <= 5; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL abort_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         if (c == 3) req = 4'b1001;
      end
      n_checks++;
      if ({lat_en_a, gnt_a} !== {1'b1, 4'b1000}) begin
         n_fails++; $display("FAIL abort_pre got=%b %b exp=1 1000", lat_en_a, gnt_a);
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({lat_en_a, ack_a, gnt_a, busy_a, lat_en_b, busy_b} !== {1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fails++; $display("FAIL abort_async got=%b %b %b %b %b %b exp=all zero", lat_en_a, ack_a, gnt_a, busy_a, lat_en_b, busy_b);
      end
      cycle();
      rst = 1'b1;
      cycle();
      n_checks++;
      if ({gnt_a, gnt_b} !== {4'b0001, 4'b0001}) begin
         n_fails++; $display("FAIL abort_regrant got=%b_%b exp=0001_0001", gnt_a, gnt_b);
      end
      for (int c = 0; c < 24; c++) begin
         if (c == 12) req = '0;
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL abort_after t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 9) == 0);
         wdata = {$urandom, $urandom, $urandom, $urandom};
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
         n_checks++;
         if ((lat_en_a && !lat_rst_a) || (lat_en_b && !lat_rst_b)) begin
            n_fails++; $display("FAIL random_en_rst_overlap got=%b%b_%b%b exp=no overlap", lat_en_a, lat_rst_a, lat_en_b, lat_rst_b);
         end
      end
      req = '0;
      clr = 1'b0;
      for (int c = 0; c < 20; c++) begin
         cycle();
         n_checks++;
         if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
            n_fails++; $display("FAIL random_drain t=%0t got=%h exp=%h", $time, {obs_a, obs_b}, {exp_a, exp_b});
         end
      end
   endtask

   initial begin
      rst   = 1'b0;
      req   = '0;
      clr   = 1'b0;
      wdata = '0;
      test_reset();
      test_single_write();
      test_fairness();
      test_clear();
      test_phase_lengths();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
